// File: rtl/axil_regs_pkg.sv
// Shared register map, response codes and address decode for the accelerator register bank.
package axil_regs_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_IRQ      = 8'h08;
    localparam logic [7:0] OFF_ARG_BASE = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned IRQ_EN_BIT      = 0;
    localparam int unsigned IRQ_PEND_BIT    = 1;

    typedef enum logic [2:0] {
        RegCtrl,
        RegStatus,
        RegIrq,
        RegArg,
        RegErr
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [5:0] idx;
    } reg_sel_t;

    // Byte offset (already truncated to the decoded width) to register selection.
    function automatic reg_sel_t decode_reg(logic [31:0] off, int unsigned num_args);
        reg_sel_t    sel;
        logic [31:0] word_off;
        word_off = off & ~32'h3;
        sel.kind = RegErr;
        sel.idx  = '0;
        if (word_off == 32'(OFF_CTRL)) begin
            sel.kind = RegCtrl;
        end else if (word_off == 32'(OFF_STATUS)) begin
            sel.kind = RegStatus;
        end else if (word_off == 32'(OFF_IRQ)) begin
            sel.kind = RegIrq;
        end else if (word_off >= 32'(OFF_ARG_BASE) &&
                     word_off < 32'(OFF_ARG_BASE) + 32'(4 * num_args)) begin
            sel.kind = RegArg;
            sel.idx  = 6'((word_off - 32'(OFF_ARG_BASE)) >> 2);
        end
        return sel;
    endfunction

endpackage

// File: rtl/axil_regs_wr_join.sv
// AXI-Lite write path: independent AW/W holding slots, join into a one-cycle commit strobe,
// and B-channel response generation.
module axil_regs_wr_join
    import axil_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    commit,
    output logic [ADDR_WIDTH-1:0]   commit_addr,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic [DATA_WIDTH/8-1:0] commit_strb,
    input  logic                    commit_err
);

    logic                    aw_held_q;
    logic                    w_held_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;

    // Ready is gated by rst_n so nothing is accepted while reset is asserted.
    assign awready = rst_n && !aw_held_q && !bvalid_q;
    assign wready  = rst_n && !w_held_q && !bvalid_q;
    assign commit  = aw_held_q && w_held_q;

    assign commit_addr = addr_q;
    assign commit_data = data_q;
    assign commit_strb = strb_q;
    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_held_q <= 1'b1;
                addr_q    <= awaddr;
            end
            if (wvalid && wready) begin
                w_held_q <= 1'b1;
                data_q   <= wdata;
                strb_q   <= wstrb;
            end
            // Slots only fill while bvalid is low, so commit and B handshake never overlap.
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= commit_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_regs_slave.sv
// AXI4-Lite register bank for one accelerator core: CTRL/STATUS/IRQ plus NUM_ARGS argument words.
// Define AXIL_REGS_IRQ_EN to add the IRQ register and the irq output.
module axil_regs_slave
    import axil_regs_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_ARGS       = 8,
    parameter int unsigned REG_ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]        S_AXI_awaddr,
    input  logic [2:0]                       S_AXI_awprot,
    input  logic                             S_AXI_awvalid,
    output logic                             S_AXI_awready,
    input  logic [AXI_DATA_WIDTH-1:0]        S_AXI_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]      S_AXI_wstrb,
    input  logic                             S_AXI_wvalid,
    output logic                             S_AXI_wready,
    output logic [1:0]                       S_AXI_bresp,
    output logic                             S_AXI_bvalid,
    input  logic                             S_AXI_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]        S_AXI_araddr,
    input  logic [2:0]                       S_AXI_arprot,
    input  logic                             S_AXI_arvalid,
    output logic                             S_AXI_arready,
    output logic [AXI_DATA_WIDTH-1:0]        S_AXI_rdata,
    output logic [1:0]                       S_AXI_rresp,
    output logic                             S_AXI_rvalid,
    input  logic                             S_AXI_rready,
    output logic                             core_start,
    input  logic                             core_done,
`ifdef AXIL_REGS_IRQ_EN
    output logic                             irq,
`endif
    output logic [NUM_ARGS*AXI_DATA_WIDTH-1:0] args
);

    logic                        commit;
    logic [AXI_ADDR_WIDTH-1:0]   c_addr;
    logic [AXI_DATA_WIDTH-1:0]   c_data;
    logic [AXI_DATA_WIDTH/8-1:0] c_strb;
    logic                        c_err;
    reg_sel_t                    wsel;
    reg_sel_t                    rsel;

    axil_regs_wr_join #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_wr_join (
        .clk         (clk),
        .rst_n       (rst_n),
        .awaddr      (S_AXI_awaddr),
        .awvalid     (S_AXI_awvalid),
        .awready     (S_AXI_awready),
        .wdata       (S_AXI_wdata),
        .wstrb       (S_AXI_wstrb),
        .wvalid      (S_AXI_wvalid),
        .wready      (S_AXI_wready),
        .bresp       (S_AXI_bresp),
        .bvalid      (S_AXI_bvalid),
        .bready      (S_AXI_bready),
        .commit      (commit),
        .commit_addr (c_addr),
        .commit_data (c_data),
        .commit_strb (c_strb),
        .commit_err  (c_err)
    );

    assign wsel  = decode_reg(32'(c_addr[REG_ADDR_WIDTH-1:0]), NUM_ARGS);
    assign rsel  = decode_reg(32'(S_AXI_araddr[REG_ADDR_WIDTH-1:0]), NUM_ARGS);
    assign c_err = (wsel.kind == RegErr);

    // Protection bits and undecoded upper address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_araddr, c_addr};

    // Core control: done is applied before start so a same-edge start is accepted.
    logic busy_q, busy_d, done_q, done_d, start_q;
    logic start_req, start_ok, done_ok;

    assign start_req = commit && (wsel.kind == RegCtrl) && c_strb[0] && c_data[CTRL_START_BIT];
    assign done_ok   = core_done && busy_q;
    assign start_ok  = start_req && (!busy_q || core_done);

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (done_ok) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (start_ok) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_ok;
        end
    end

    assign core_start = start_q;

    logic [NUM_ARGS*AXI_DATA_WIDTH-1:0] args_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            args_q <= '0;
        end else if (commit && (wsel.kind == RegArg)) begin
            for (int b = 0; b < int'(AXI_DATA_WIDTH / 8); b++) begin
                if (c_strb[b]) begin
                    args_q[int'(wsel.idx) * AXI_DATA_WIDTH + 8 * b +: 8] <= c_data[8 * b +: 8];
                end
            end
        end
    end

    assign args = args_q;

`ifdef AXIL_REGS_IRQ_EN
    logic irq_en_q, irq_pend_q, irq_q;
    logic irq_wr;

    assign irq_wr = commit && (wsel.kind == RegIrq) && c_strb[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (irq_wr) begin
                irq_en_q <= c_data[IRQ_EN_BIT];
            end
            // A new completion wins over a simultaneous clear.
            if (done_ok) begin
                irq_pend_q <= 1'b1;
            end else if (irq_wr && c_data[IRQ_PEND_BIT]) begin
                irq_pend_q <= 1'b0;
            end
            irq_q <= irq_en_q & irq_pend_q;
        end
    end

    assign irq = irq_q;
`endif

    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic                      rd_err;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rsel.kind)
            RegStatus: begin
                rd_data[STATUS_BUSY_BIT] = busy_q;
                rd_data[STATUS_DONE_BIT] = done_q;
            end
`ifdef AXIL_REGS_IRQ_EN
            RegIrq: begin
                rd_data[IRQ_EN_BIT]   = irq_en_q;
                rd_data[IRQ_PEND_BIT] = irq_pend_q;
            end
`endif
            RegArg:  rd_data = args_q[int'(rsel.idx) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            RegErr:  rd_err  = 1'b1;
            default: rd_data = '0;
        endcase
    end

    logic                      rvalid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;

    assign S_AXI_arready = rst_n && !rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (S_AXI_arvalid && S_AXI_arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_rvalid = rvalid_q;
    assign S_AXI_rdata  = rdata_q;
    assign S_AXI_rresp  = rresp_q;

endmodule
